// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 frame receiver.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_PARITY  = 2'd1;
    localparam logic [1:0] ERR_STOP    = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    localparam int DATA_BITS  = 8;
    localparam int FRAME_BITS = 11;

endpackage

// File: rtl/ps2_sync_edge.sv
// Input conditioning for the PS/2 lines: 2-flop synchronisers, optional
// ps2c glitch filter (enabled by defining PS2_RX_GLITCH_FILTER_EN) and
// ps2c falling-edge detection. Synchroniser flops reset to 1 (idle bus).
module ps2_sync_edge #(
    parameter int FILTER_LEN = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ps2c,
    input  logic ps2d,
    output logic fe,
    output logic ps2d_s
);

    logic [1:0] c_sync;
    logic [1:0] d_sync;
    logic       c_cur;
    logic       c_prev;

    if (FILTER_LEN < 1) begin : g_bad_filter_len
        $error("FILTER_LEN must be at least 1");
    end

    // Two-stage synchronisers for both raw lines.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_sync <= 2'b11;
            d_sync <= 2'b11;
        end else begin
            c_sync <= {c_sync[0], ps2c};
            d_sync <= {d_sync[0], ps2d};
        end
    end

`ifdef PS2_RX_GLITCH_FILTER_EN
    localparam int CW = $clog2(FILTER_LEN + 1);
    logic [CW-1:0] flt_cnt;
    logic          c_flt;

    // Filtered clock follows the synchronised one only after FILTER_LEN
    // consecutive differing samples; shorter pulses are swallowed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flt_cnt <= '0;
            c_flt   <= 1'b1;
        end else if (c_sync[1] == c_flt) begin
            flt_cnt <= '0;
        end else if (flt_cnt == CW'(FILTER_LEN - 1)) begin
            flt_cnt <= '0;
            c_flt   <= c_sync[1];
        end else begin
            flt_cnt <= flt_cnt + 1'b1;
        end
    end

    assign c_cur = c_flt;
`else
    assign c_cur = c_sync[1];
`endif

    // Previous clock level for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) c_prev <= 1'b1;
        else        c_prev <= c_cur;
    end

    assign fe     = c_prev & ~c_cur;
    assign ps2d_s = d_sync[1];

endmodule

// File: rtl/ps2_rx_frame.sv
// PS/2 device-to-host frame receiver: start, 8 data bits LSB first, odd
// parity, stop. One-cycle rx_valid or rx_err strobe per frame, registered
// one cycle after the stop-bit edge. Build option: PS2_RX_GLITCH_FILTER_EN.
module ps2_rx_frame
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int FILTER_LEN     = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2c,
    input  logic       ps2d,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_err,
    output logic [1:0] err_code,
    output logic       busy
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);

    logic          fe;
    logic          ps2d_s;
    state_t        state, state_nx;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          acc;
    logic          par_ok;
    logic [TW-1:0] to_cnt;
    logic          expired;
    logic          ok_nx;
    logic          err_nx;
    logic [1:0]    code_nx;

    ps2_sync_edge #(.FILTER_LEN(FILTER_LEN)) u_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .ps2c   (ps2c),
        .ps2d   (ps2d),
        .fe     (fe),
        .ps2d_s (ps2d_s)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next state and frame verdict; an edge in the expiry cycle wins.
    always_comb begin
        state_nx = state;
        ok_nx    = 1'b0;
        err_nx   = 1'b0;
        code_nx  = ERR_NONE;
        expired  = (state != IDLE) && (to_cnt == TW'(TIMEOUT_CYCLES - 1));
        case (state)
            IDLE:   if (fe && !ps2d_s) state_nx = DATA;
            DATA:   if (fe && bit_cnt == 3'(DATA_BITS - 1)) state_nx = PARITY;
            PARITY: if (fe) state_nx = STOP;
            STOP: begin
                if (fe) begin
                    state_nx = IDLE;
                    if (!ps2d_s) begin
                        err_nx  = 1'b1;
                        code_nx = ERR_STOP;
                    end else if (!par_ok) begin
                        err_nx  = 1'b1;
                        code_nx = ERR_PARITY;
                    end else begin
                        ok_nx   = 1'b1;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
        if (!fe && expired) begin
            state_nx = IDLE;
            err_nx   = 1'b1;
            code_nx  = ERR_TIMEOUT;
        end
    end

    // Deserialiser, parity accumulator and inter-edge timeout counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt <= '0;
            shreg   <= '0;
            acc     <= 1'b0;
            par_ok  <= 1'b0;
            to_cnt  <= '0;
        end else begin
            if (state == IDLE) begin
                bit_cnt <= '0;
                acc     <= 1'b0;
            end else if (state == DATA && fe) begin
                shreg[bit_cnt] <= ps2d_s;
                acc            <= acc ^ ps2d_s;
                bit_cnt        <= bit_cnt + 1'b1;
            end else if (state == PARITY && fe) begin
                par_ok <= acc ^ ps2d_s;
            end
            if (fe || state == IDLE) to_cnt <= '0;
            else                     to_cnt <= to_cnt + 1'b1;
        end
    end

    // Registered strobes; rx_data only moves on a good frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data  <= '0;
            rx_valid <= 1'b0;
            rx_err   <= 1'b0;
            err_code <= ERR_NONE;
        end else begin
            rx_valid <= ok_nx;
            rx_err   <= err_nx;
            err_code <= code_nx;
            if (ok_nx) rx_data <= shreg;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_ps2_rx_frame.sv
// Scoreboard bench for ps2_rx_frame: stimulus pushes the expected outcome of
// each frame, a negedge monitor pops and checks every strobe.
module tb_ps2_rx_frame;
    import ps2_pkg::*;

    localparam int HALF = 20;
    localparam int T    = 300;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ps2c = 1'b1;
    logic       ps2d = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_err;
    logic [1:0] err_code;
    logic       busy;

    typedef struct {
        bit         is_err;
        logic [7:0] data;
        logic [1:0] code;
        int         earliest;
        int         latest;
    } exp_t;

    exp_t       sb[$];
    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    logic [7:0] last_good = 8'h00;

    ps2_rx_frame #(.TIMEOUT_CYCLES(T)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ps2c     (ps2c),
        .ps2d     (ps2d),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_err   (rx_err),
        .err_code (err_code),
        .busy     (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every strobe must match the oldest pending expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rx_valid && rx_err) begin
                total++;
                bad++;
                $display("FAIL both_strobes: valid=1 err=1 at cycle %0d, required exclusive", cyc);
            end else if (rx_valid || rx_err) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_strobe: valid=%b err=%b code=%0d data=%h, required none",
                             rx_valid, rx_err, err_code, rx_data);
                end else begin
                    exp_t e;
                    bit   ok;
                    e = sb.pop_front();
                    if (e.is_err)
                        ok = rx_err && err_code == e.code && rx_data == last_good;
                    else
                        ok = rx_valid && err_code == ERR_NONE && rx_data == e.data;
                    ok = ok && cyc >= e.earliest && cyc <= e.latest;
                    if (!ok)
                        $display("FAIL strobe: got valid=%b err=%b code=%0d data=%h cyc=%0d; required err=%0b code=%0d data=%h window=[%0d,%0d]",
                                 rx_valid, rx_err, err_code, rx_data, cyc, e.is_err, e.code,
                                 e.is_err ? last_good : e.data, e.earliest, e.latest);
                    if (!ok) bad++;
                    if (!e.is_err) last_good = e.data;
                end
            end
        end
    end

    task automatic ps2_bit(input logic b);
        ps2d = b;
        repeat (HALF) @(negedge clk);
        ps2c = 1'b0;
        repeat (HALF) @(negedge clk);
        ps2c = 1'b1;
    endtask

    task automatic idle(input int n);
        ps2c = 1'b1;
        ps2d = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Reference: odd parity over data+parity; stop error outranks parity.
    task automatic send_frame(input logic [7:0] d, input bit bad_par, input logic stop);
        logic par;
        exp_t e;
        int   ones;
        par = ~(^d);
        if (bad_par) par = ~par;
        ps2_bit(1'b0);
        for (int i = 0; i < FRAME_BITS - 3; i++) ps2_bit(d[i]);
        ps2_bit(par);
        ones = $countones({d, par});
        e.data = d;
        if (stop == 1'b0)      begin e.is_err = 1'b1; e.code = ERR_STOP;   end
        else if (ones % 2 == 0) begin e.is_err = 1'b1; e.code = ERR_PARITY; end
        else                   begin e.is_err = 1'b0; e.code = ERR_NONE;   end
        e.earliest = cyc + HALF;
        e.latest   = cyc + HALF + 12;
        sb.push_back(e);
        ps2_bit(stop);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d expected strobes never seen, required 0 pending", sb.size());
            sb.delete();
        end
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        total++;
        if (got !== req) begin
            bad++;
            $display("FAIL %s: got %h required %h", name, got, req);
        end
    endtask

    initial begin
        exp_t e;
        repeat (5) @(negedge clk);
        check("reset_outputs", {rx_data, rx_valid, rx_err, err_code, busy}, 32'd0);
        rst_n = 1'b1;
        idle(10);

        // Single good frame, busy falls afterwards.
        send_frame(8'h3A, 0, 1'b1);
        drain();
        idle(5);
        check("busy_after_frame", {31'd0, busy}, 32'd0);

        // Back-to-back frames with no idle gap.
        send_frame(8'h3A, 0, 1'b1);
        send_frame(8'h11, 0, 1'b1);
        drain();

        // Parity error, then stop error followed by a good frame.
        send_frame(8'h3A, 1, 1'b1);
        send_frame(8'h11, 0, 1'b0);
        send_frame(8'h11, 0, 1'b1);
        drain();

        // Timeout after start + 5 data bits, then a good frame.
        ps2_bit(1'b0);
        for (int i = 0; i < 5; i++) ps2_bit(1'b1);
        check("busy_mid_frame", {31'd0, busy}, 32'd1);
        e.is_err = 1'b1; e.code = ERR_TIMEOUT; e.data = 8'h00;
        e.earliest = cyc - HALF + T;
        e.latest   = cyc - HALF + T + 12;
        sb.push_back(e);
        idle(T + 40);
        drain();
        check("busy_after_timeout", {31'd0, busy}, 32'd0);
        send_frame(8'h3A, 0, 1'b1);
        drain();

        // Lone pulse with data high is not a start bit.
        ps2_bit(1'b1);
        idle(T + 40);
        check("busy_after_bad_start", {31'd0, busy}, 32'd0);

        // Reset in the middle of a frame.
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        rst_n = 1'b0;
        last_good = 8'h00;
        repeat (3) @(negedge clk);
        check("midreset_outputs", {rx_data, rx_valid, rx_err, err_code, busy}, 32'd0);
        rst_n = 1'b1;
        idle(50);
        send_frame(8'h11, 0, 1'b1);
        drain();

        // Randomized frames with random errors and gaps.
        for (int k = 0; k < 25; k++) begin
            logic [7:0] d;
            bit         bp;
            logic       st;
            d  = 8'($urandom);
            bp = ($urandom_range(0, 5) == 0);
            st = ($urandom_range(0, 5) == 0) ? 1'b0 : 1'b1;
            send_frame(d, bp, st);
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 30));
        end
        drain();

        // Quiet bus: nothing may happen.
        idle(T * 2);
        check("quiet_busy", {31'd0, busy}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
